// File: rtl/pc_ctrl_pkg.sv
// Shared codes and state enumeration for the PC-source sequencer.
package pc_ctrl_pkg;

  localparam logic [2:0] RK_SEQ  = 3'd0;
  localparam logic [2:0] RK_BEQ  = 3'd1;
  localparam logic [2:0] RK_BNE  = 3'd2;
  localparam logic [2:0] RK_JUMP = 3'd3;
  localparam logic [2:0] RK_JR   = 3'd4;
  localparam logic [2:0] RK_RTE  = 3'd5;

  localparam logic [2:0] PCS_PLUS4  = 3'd0;
  localparam logic [2:0] PCS_BRANCH = 3'd1;
  localparam logic [2:0] PCS_JUMP   = 3'd2;
  localparam logic [2:0] PCS_REG    = 3'd3;
  localparam logic [2:0] PCS_VEC    = 3'd4;
  localparam logic [2:0] PCS_EPC    = 3'd5;

  localparam logic [1:0] CAUSE_OPCODE = 2'd0;
  localparam logic [1:0] CAUSE_OVF    = 2'd1;
  localparam logic [1:0] CAUSE_DIV0   = 2'd2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COMMIT   = 3'd1,
    BRANCH   = 3'd2,
    EXC_EPC  = 3'd3,
    EXC_RD   = 3'd4,
    EXC_LOAD = 3'd5
  } state_t;

  // One vector byte per cause, laid out consecutively from the base.
  function automatic logic [7:0] vec_address(input logic [7:0] base, input logic [1:0] cause);
    return base + {6'd0, cause};
  endfunction

endpackage

// File: rtl/pc_source_ctrl_if.sv
// Request/response bundle between the main control unit and the PC-source sequencer.
interface pc_source_ctrl_if;
  import pc_ctrl_pkg::*;

  logic       req;
  logic [2:0] req_kind;
  logic       alu_zero;
  logic       exc_opcode;
  logic       exc_ovf;
  logic       exc_div0;
  logic       busy;
  logic       done;
  logic [2:0] pc_source;
  logic       pc_write;
  logic       epc_write;
  logic       vec_rd;
  logic [7:0] vec_addr;
  logic [1:0] exc_cause;

  modport master (
    output req, req_kind, alu_zero, exc_opcode, exc_ovf, exc_div0,
    input  busy, done, pc_source, pc_write, epc_write, vec_rd, vec_addr, exc_cause
  );

  modport slave (
    input  req, req_kind, alu_zero, exc_opcode, exc_ovf, exc_div0,
    output busy, done, pc_source, pc_write, epc_write, vec_rd, vec_addr, exc_cause
  );
endinterface

// File: rtl/pc_ctrl_wait_cnt.sv
// Loadable 4-bit down-counter with zero flag; times the exception-vector read.
module pc_ctrl_wait_cnt (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic [3:0] cnt,
  output logic       zero
);

  always_ff @(posedge clk) begin
    if (!reset)
      cnt <= 4'd0;
    else if (load)
      cnt <= load_val;
    else if (dec && (cnt != 4'd0))
      cnt <= cnt - 4'd1;
  end

  assign zero = (cnt == 4'd0);

endmodule

// File: rtl/pc_source_ctrl.sv
// Per-instruction PC-source/PC-write sequencer with exception entry.
// Optional taken-branch counter enabled by defining BRANCH_STATS_EN.
module pc_source_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int         MEM_LAT  = 2,       // 1..15
  parameter logic [7:0] VEC_BASE = 8'd253
) (
  input  logic              clk,
  input  logic              reset,
  pc_source_ctrl_if.slave   bus
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]       br_taken_cnt
`endif
);

  localparam logic [3:0] WAIT_LOAD = 4'(MEM_LAT - 1);

  state_t     state, state_nx;
  logic [2:0] sel_q, sel_nx;
  logic       bne_q, bne_nx;
  logic [1:0] cause_q, cause_nx;
  logic [7:0] vaddr_q;
  logic       vaddr_ld;
  logic       cnt_load, cnt_dec;
  logic [3:0] cnt;
  logic       cnt_zero;

  logic       busy, done, pc_write, epc_write, vec_rd;
  logic [2:0] pc_source;

  pc_ctrl_wait_cnt u_wait (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (WAIT_LOAD),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cause_q <= CAUSE_OPCODE;
    end else begin
      state   <= state_nx;
      cause_q <= cause_nx;
    end
  end

  // Datapath-side latches: only meaningful once the FSM has selected them.
  always_ff @(posedge clk) begin
    sel_q <= sel_nx;
    bne_q <= bne_nx;
    if (vaddr_ld)
      vaddr_q <= vec_address(VEC_BASE, cause_q);
  end

  always_comb begin
    state_nx  = state;
    sel_nx    = sel_q;
    bne_nx    = bne_q;
    cause_nx  = cause_q;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    vaddr_ld  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    pc_source = PCS_PLUS4;
    pc_write  = 1'b0;
    epc_write = 1'b0;
    vec_rd    = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (bus.req) begin
          // Illegal kinds 6/7 are folded into the invalid-opcode exception.
          if (bus.exc_opcode || (bus.req_kind > RK_RTE)) begin
            cause_nx = CAUSE_OPCODE;
            state_nx = EXC_EPC;
          end else if (bus.exc_ovf) begin
            cause_nx = CAUSE_OVF;
            state_nx = EXC_EPC;
          end else if (bus.exc_div0) begin
            cause_nx = CAUSE_DIV0;
            state_nx = EXC_EPC;
          end else begin
            case (bus.req_kind)
              RK_SEQ:  begin sel_nx = PCS_PLUS4; state_nx = COMMIT; end
              RK_JUMP: begin sel_nx = PCS_JUMP;  state_nx = COMMIT; end
              RK_JR:   begin sel_nx = PCS_REG;   state_nx = COMMIT; end
              RK_RTE:  begin sel_nx = PCS_EPC;   state_nx = COMMIT; end
              RK_BEQ:  begin bne_nx = 1'b0;      state_nx = BRANCH; end
              RK_BNE:  begin bne_nx = 1'b1;      state_nx = BRANCH; end
              default: begin cause_nx = CAUSE_OPCODE; state_nx = EXC_EPC; end
            endcase
          end
        end
      end
      COMMIT: begin
        pc_source = sel_q;
        pc_write  = 1'b1;
        done      = 1'b1;
        state_nx  = IDLE;
      end
      BRANCH: begin
        pc_source = PCS_BRANCH;
        pc_write  = bne_q ? !bus.alu_zero : bus.alu_zero;
        done      = 1'b1;
        state_nx  = IDLE;
      end
      EXC_EPC: begin
        epc_write = 1'b1;
        cnt_load  = 1'b1;
        vaddr_ld  = 1'b1;
        state_nx  = EXC_RD;
      end
      EXC_RD: begin
        vec_rd = 1'b1;
        if (cnt_zero)
          state_nx = EXC_LOAD;
        else
          cnt_dec = 1'b1;
      end
      EXC_LOAD: begin
        pc_source = PCS_VEC;
        pc_write  = 1'b1;
        done      = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.pc_source = pc_source;
  assign bus.pc_write  = pc_write;
  assign bus.epc_write = epc_write;
  assign bus.vec_rd    = vec_rd;
  assign bus.vec_addr  = vaddr_q;
  assign bus.exc_cause = cause_q;

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset)
      br_taken_cnt <= 16'd0;
    else if ((state == BRANCH) && pc_write && (br_taken_cnt != 16'hFFFF))
      br_taken_cnt <= br_taken_cnt + 16'd1;
  end
`endif

endmodule
